// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates I-cache line fills and D-cache line fills / write-throughs
// onto a single 64-bit system bus. Reads assemble BLOCKSZ/WIDTH beats into one line;
// writes are single-beat. Completion is signalled with a one-cycle valid pulse.
module mem_arbiter #(
  parameter int BLOCKSZ     = 512,
  parameter int WIDTH       = 64,
  parameter int ADDRESSSIZE = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_req,
  input  logic [ADDRESSSIZE-1:0] i_addr,
  output logic [BLOCKSZ-1:0]     i_data_out,
  output logic                   i_data_valid,
  input  logic                   d_req,
  input  logic                   d_wr_en,
  input  logic [ADDRESSSIZE-1:0] d_addr,
  input  logic [WIDTH-1:0]       d_wdata,
  output logic [BLOCKSZ-1:0]     d_data_out,
  output logic                   d_data_valid,
  output logic                   bus_req,
  input  logic                   bus_req_ack,
  output logic                   bus_wr,
  output logic [ADDRESSSIZE-1:0] bus_addr,
  output logic [WIDTH-1:0]       bus_wdata,
  input  logic [WIDTH-1:0]       bus_resp,
  input  logic                   bus_resp_valid
);

  localparam int NBEATS = BLOCKSZ / WIDTH;
  localparam int CNTW   = $clog2(NBEATS);
  localparam int WW     = $clog2(WIDTH);
  localparam logic [CNTW-1:0]        LAST_BEAT = CNTW'(NBEATS - 1);
  localparam logic [ADDRESSSIZE-1:0] LINE_MASK = ~ADDRESSSIZE'(BLOCKSZ / 8 - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_BEATS = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  logic [1:0]             state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   last_grant_q, last_grant_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [BLOCKSZ-1:0]     line_q, line_d;
  logic                   i_pend_q, i_pend_d;
  logic [ADDRESSSIZE-1:0] i_addr_q, i_addr_d;
  logic                   d_pend_q, d_pend_d;
  logic                   d_wr_q, d_wr_d;
  logic [ADDRESSSIZE-1:0] d_addr_q, d_addr_d;
  logic [WIDTH-1:0]       d_wdata_q, d_wdata_d;
  logic [BLOCKSZ-1:0]     i_data_q, i_data_d;
  logic [BLOCKSZ-1:0]     d_data_q, d_data_d;
  logic                   i_valid_q, i_valid_d;
  logic                   d_valid_q, d_valid_d;
  logic                   bus_req_q, bus_req_d;
  logic                   bus_wr_q, bus_wr_d;
  logic [ADDRESSSIZE-1:0] bus_addr_q, bus_addr_d;
  logic [WIDTH-1:0]       bus_wdata_q, bus_wdata_d;

  // Capture / grant helpers. A port's pending flag is being cleared in DONE, so a
  // request arriving that same cycle must still be taken rather than dropped.
  logic                   i_clear_s, i_take_s, i_eff_s;
  logic                   d_clear_s, d_take_s, d_eff_s;
  logic [ADDRESSSIZE-1:0] i_eff_addr_s, d_eff_addr_s, gnt_addr_s;
  logic                   d_eff_wr_s, gnt_wr_s, gnt_port_s, gnt_valid_s;
  logic [WIDTH-1:0]       d_eff_wdata_s, gnt_wdata_s;
  logic [BLOCKSZ-1:0]     beat_line_s;
  logic [CNTW+WW-1:0]     beat_base_s;

  // Effective request view (latched or same-cycle) and round-robin grant selection.
  always_comb begin
    i_clear_s     = (state_q == ST_DONE) && (owner_q == PORT_I);
    d_clear_s     = (state_q == ST_DONE) && (owner_q == PORT_D);
    i_take_s      = i_req && (!i_pend_q || i_clear_s);
    d_take_s      = d_req && (!d_pend_q || d_clear_s);
    i_eff_s       = i_pend_q || i_req;
    d_eff_s       = d_pend_q || d_req;
    i_eff_addr_s  = i_take_s ? i_addr  : i_addr_q;
    d_eff_addr_s  = d_take_s ? d_addr  : d_addr_q;
    d_eff_wr_s    = d_take_s ? d_wr_en : d_wr_q;
    d_eff_wdata_s = d_take_s ? d_wdata : d_wdata_q;
    gnt_valid_s   = (state_q == ST_IDLE) && (i_eff_s || d_eff_s);
    if (i_eff_s && d_eff_s) begin
      gnt_port_s = ~last_grant_q;
    end else if (d_eff_s) begin
      gnt_port_s = PORT_D;
    end else begin
      gnt_port_s = PORT_I;
    end
    if (gnt_port_s == PORT_D) begin
      gnt_addr_s  = d_eff_addr_s;
      gnt_wr_s    = d_eff_wr_s;
      gnt_wdata_s = d_eff_wr_s ? d_eff_wdata_s : {WIDTH{1'b0}};
    end else begin
      gnt_addr_s  = i_eff_addr_s;
      gnt_wr_s    = 1'b0;
      gnt_wdata_s = {WIDTH{1'b0}};
    end
    beat_base_s = {cnt_q, {WW{1'b0}}};
    beat_line_s = line_q;
    beat_line_s[beat_base_s +: WIDTH] = bus_resp;
  end

  // Pending-flag and request-latch next state for both requesters.
  always_comb begin
    i_addr_d  = i_addr_q;
    d_wr_d    = d_wr_q;
    d_addr_d  = d_addr_q;
    d_wdata_d = d_wdata_q;
    if (i_take_s) begin
      i_pend_d = 1'b1;
      i_addr_d = i_addr;
    end else if (i_clear_s) begin
      i_pend_d = 1'b0;
    end else begin
      i_pend_d = i_pend_q;
    end
    if (d_take_s) begin
      d_pend_d  = 1'b1;
      d_wr_d    = d_wr_en;
      d_addr_d  = d_addr;
      d_wdata_d = d_wdata;
    end else if (d_clear_s) begin
      d_pend_d = 1'b0;
    end else begin
      d_pend_d = d_pend_q;
    end
  end

  // Transaction FSM: grant, bus handshake, beat assembly and completion pulse.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    line_d       = line_q;
    bus_req_d    = bus_req_q;
    bus_wr_d     = bus_wr_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    i_data_d     = i_data_q;
    d_data_d     = d_data_q;
    i_valid_d    = 1'b0;
    d_valid_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid_s) begin
          state_d      = ST_ISSUE;
          owner_d      = gnt_port_s;
          last_grant_d = gnt_port_s;
          bus_req_d    = 1'b1;
          bus_wr_d     = gnt_wr_s;
          bus_addr_d   = gnt_wr_s ? gnt_addr_s : (gnt_addr_s & LINE_MASK);
          bus_wdata_d  = gnt_wdata_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus_req_ack) begin
          bus_req_d = 1'b0;
          cnt_d     = {CNTW{1'b0}};
          if (bus_wr_q) begin
            state_d   = ST_DONE;
            d_valid_d = 1'b1;
          end else begin
            state_d = ST_BEATS;
          end
        end else begin
          bus_req_d = 1'b1;
        end
      end
      ST_BEATS: begin
        if (bus_resp_valid) begin
          line_d = beat_line_s;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = {CNTW{1'b0}};
            state_d = ST_DONE;
            if (owner_q == PORT_I) begin
              i_data_d  = beat_line_s;
              i_valid_d = 1'b1;
            end else begin
              d_data_d  = beat_line_s;
              d_valid_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = ST_BEATS;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = {CNTW{1'b0}};
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset aborts any transaction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= PORT_I;
      last_grant_q <= PORT_I;
      cnt_q        <= {CNTW{1'b0}};
      line_q       <= {BLOCKSZ{1'b0}};
      i_pend_q     <= 1'b0;
      i_addr_q     <= {ADDRESSSIZE{1'b0}};
      d_pend_q     <= 1'b0;
      d_wr_q       <= 1'b0;
      d_addr_q     <= {ADDRESSSIZE{1'b0}};
      d_wdata_q    <= {WIDTH{1'b0}};
      i_data_q     <= {BLOCKSZ{1'b0}};
      d_data_q     <= {BLOCKSZ{1'b0}};
      i_valid_q    <= 1'b0;
      d_valid_q    <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_addr_q   <= {ADDRESSSIZE{1'b0}};
      bus_wdata_q  <= {WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      i_pend_q     <= i_pend_d;
      i_addr_q     <= i_addr_d;
      d_pend_q     <= d_pend_d;
      d_wr_q       <= d_wr_d;
      d_addr_q     <= d_addr_d;
      d_wdata_q    <= d_wdata_d;
      i_data_q     <= i_data_d;
      d_data_q     <= d_data_d;
      i_valid_q    <= i_valid_d;
      d_valid_q    <= d_valid_d;
      bus_req_q    <= bus_req_d;
      bus_wr_q     <= bus_wr_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
    end
  end

  assign i_data_out   = i_data_q;
  assign i_data_valid = i_valid_q;
  assign d_data_out   = d_data_q;
  assign d_data_valid = d_valid_q;
  assign bus_req      = bus_req_q;
  assign bus_wr       = bus_wr_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;

endmodule
